// File: rtl/apb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_pkg
//  Description : Shared types and default widths for the APB master bridge.
//                Provides the bridge FSM state enumeration and the default
//                APB address/data widths used by the bridge parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_master_pkg;

    localparam int APB_AW_DEF = 32;
    localparam int APB_DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

endpackage : apb_master_pkg
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Saturating wait-state counter for the APB ACCESS phase.
//                o_hit is asserted in the cycle whose increment brings the
//                count up to TIMEOUT_CYCLES, so the caller can terminate the
//                transfer at the end of exactly TIMEOUT_CYCLES waiting cycles.
//                TIMEOUT_CYCLES = 0 disables o_hit entirely.
//  Ports       : pclk   - clock, rising edge
//                prst_n - asynchronous active-low reset
//                i_clr  - synchronous clear (priority over i_en)
//                i_en   - count this cycle
//                o_hit  - threshold reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic pclk,
    input  logic prst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    // Width is derived only; a zero threshold still needs a 1-bit register.
    localparam int unsigned TO_CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_CW-1:0] c_max  = TO_CW'(TIMEOUT_CYCLES);
    localparam logic [TO_CW-1:0] c_last = (TIMEOUT_CYCLES == 0) ? '0 : TO_CW'(TIMEOUT_CYCLES - 1);

    logic [TO_CW-1:0] cnt_q;
    logic [TO_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != c_max)) begin
            cnt_d = cnt_q + TO_CW'(1);
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_hit = (TIMEOUT_CYCLES != 0) && i_en && (cnt_q == c_last);

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Command-driven APB4 initiator. Accepts one command at a
//                time on a valid/ready stream, runs an APB SETUP/ACCESS
//                transfer and returns the result on a valid/ready response
//                stream. A bounded wait-state timer ends transfers whose
//                slave never raises pready.
//  Ports       : pclk, prst_n            - clock / async active-low reset
//                cmd_*                   - command stream (addr, write,
//                                          wdata, strb)
//                rsp_*                   - response stream (rdata, slverr,
//                                          timeout)
//                m_apb_*                 - APB4 master port
//                busy                    - bridge not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int          APB_AW         = APB_AW_DEF,
    parameter int          APB_DW         = APB_DW_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                pclk,
    input  logic                prst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [APB_AW-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [APB_DW-1:0]   cmd_wdata,
    input  logic [APB_DW/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [APB_DW-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                rsp_timeout,
    output logic [APB_AW-1:0]   m_apb_paddr,
    output logic                m_apb_psel,
    output logic                m_apb_penable,
    output logic                m_apb_pwrite,
    output logic [APB_DW-1:0]   m_apb_pwdata,
    output logic [APB_DW/8-1:0] m_apb_pstrb,
    input  logic                m_apb_pready,
    input  logic [APB_DW-1:0]   m_apb_prdata,
    input  logic                m_apb_pslverr,
    output logic                busy
);

    // Response payload; width follows the APB_DW parameter of this instance.
    typedef struct packed {
        logic [APB_DW-1:0] rdata;
        logic              slverr;
        logic              timeout;
    } apb_mst_rsp_t;

    apb_mst_state_e    state_q,  state_d;
    logic [APB_AW-1:0]   paddr_q,  paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [APB_DW-1:0]   pwdata_q, pwdata_d;
    logic [APB_DW/8-1:0] pstrb_q,  pstrb_d;
    apb_mst_rsp_t      rsp_q,    rsp_d;

    logic timer_clr;
    logic timer_en;
    logic timer_hit;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk   (pclk),
        .prst_n (prst_n),
        .i_clr  (timer_clr),
        .i_en   (timer_en),
        .o_hit  (timer_hit)
    );

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_d         = rsp_q;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        m_apb_psel    = 1'b0;
        m_apb_penable = 1'b0;
        busy          = 1'b1;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    // APB4 reads carry no strobes; wdata is zeroed too so a
                    // read never exposes stale write data on the bus.
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrb_d   = cmd_write ? cmd_strb  : '0;
                    timer_clr = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                m_apb_psel = 1'b1;
                state_d    = ACCESS;
            end
            ACCESS: begin
                m_apb_psel    = 1'b1;
                m_apb_penable = 1'b1;
                // pready is checked first so it wins over a same-cycle timeout.
                if (m_apb_pready) begin
                    rsp_d.rdata   = pwrite_q ? '0 : m_apb_prdata;
                    rsp_d.slverr  = m_apb_pslverr;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else begin
                    timer_en = 1'b1;
                    if (timer_hit) begin
                        rsp_d.rdata   = '0;
                        rsp_d.slverr  = 1'b1;
                        rsp_d.timeout = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rsp_q    <= rsp_d;
        end
    end

    assign m_apb_paddr  = paddr_q;
    assign m_apb_pwrite = pwrite_q;
    assign m_apb_pwdata = pwdata_q;
    assign m_apb_pstrb  = pstrb_q;
    assign rsp_rdata    = rsp_q.rdata;
    assign rsp_slverr   = rsp_q.slverr;
    assign rsp_timeout  = rsp_q.timeout;

endmodule : apb_master_bridge
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Self-checking bench for apb_master_bridge. A cycle-level
//                APB slave and a transaction-level reference model live in
//                the bench; expected bus timing and responses are derived
//                from wait-state count, direction and timeout threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          pclk = 1'b0;
    logic          prst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_write = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic [AW-1:0] m_apb_paddr;
    logic          m_apb_psel;
    logic          m_apb_penable;
    logic          m_apb_pwrite;
    logic [DW-1:0] m_apb_pwdata;
    logic [SW-1:0] m_apb_pstrb;
    logic          m_apb_pready = 1'b0;
    logic [DW-1:0] m_apb_prdata = '0;
    logic          m_apb_pslverr = 1'b0;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .APB_AW         (AW),
        .APB_DW         (DW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .pclk          (pclk),
        .prst_n        (prst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_write     (cmd_write),
        .cmd_wdata     (cmd_wdata),
        .cmd_strb      (cmd_strb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_slverr    (rsp_slverr),
        .rsp_timeout   (rsp_timeout),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_pstrb   (m_apb_pstrb),
        .m_apb_pready  (m_apb_pready),
        .m_apb_prdata  (m_apb_prdata),
        .m_apb_pslverr (m_apb_pslverr),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One complete command/response transaction, entered and left at a
    // falling edge with the bridge idle. waits = number of ACCESS cycles the
    // slave holds pready low before raising it.
    task automatic run_txn(input logic [AW-1:0] addr, input logic wr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input int waits, input logic [DW-1:0] sdata,
                           input logic serr, input int rsp_hold, input logic keep_valid);
        logic [DW-1:0] e_wdata;
        logic [SW-1:0] e_strb;
        logic [DW-1:0] e_rdata;
        logic          e_err;
        logic          e_to;
        int            len;

        // Reference model: transfer outcome from the protocol rules.
        e_wdata = wr ? wdata : '0;
        e_strb  = wr ? strb  : '0;
        e_to    = (waits >= TO);
        len     = e_to ? TO : waits + 1;
        e_rdata = (e_to || wr) ? '0 : sdata;
        e_err   = e_to ? 1'b1 : serr;

        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wdata;
        cmd_strb  = strb;

        @(negedge pclk);
        // Keep valid high with junk that the bridge must ignore.
        cmd_valid = keep_valid;
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = SW'($urandom);
        chk("setup_psel", m_apb_psel, 1);
        chk("setup_penable", m_apb_penable, 0);
        chk("setup_paddr", m_apb_paddr, addr);
        chk("setup_pwrite", m_apb_pwrite, wr);
        chk("setup_pwdata", m_apb_pwdata, e_wdata);
        chk("setup_pstrb", m_apb_pstrb, e_strb);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_busy", busy, 1);

        for (int k = 1; k <= len; k++) begin
            @(negedge pclk);
            chk("acc_psel", m_apb_psel, 1);
            chk("acc_penable", m_apb_penable, 1);
            chk("acc_paddr", m_apb_paddr, addr);
            chk("acc_pwdata", m_apb_pwdata, e_wdata);
            chk("acc_pstrb", m_apb_pstrb, e_strb);
            chk("acc_rsp_valid", rsp_valid, 0);
            if (k == waits + 1) begin
                m_apb_pready  = 1'b1;
                m_apb_prdata  = sdata;
                m_apb_pslverr = serr;
            end else begin
                m_apb_pready  = 1'b0;
                m_apb_prdata  = $urandom;
                m_apb_pslverr = 1'($urandom);
            end
        end

        @(negedge pclk);
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
        m_apb_prdata  = $urandom;
        chk("resp_valid", rsp_valid, 1);
        chk("resp_psel", m_apb_psel, 0);
        chk("resp_penable", m_apb_penable, 0);
        chk("resp_rdata", rsp_rdata, e_rdata);
        chk("resp_slverr", rsp_slverr, e_err);
        chk("resp_timeout", rsp_timeout, e_to);
        chk("resp_paddr_held", m_apb_paddr, addr);
        chk("resp_cmd_ready", cmd_ready, 0);

        for (int h = 0; h < rsp_hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge pclk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, e_rdata);
            chk("hold_slverr", rsp_slverr, e_err);
            chk("hold_psel", m_apb_psel, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
        end

        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_psel", m_apb_psel, 0);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_psel", m_apb_psel, 0);
        chk("rst_penable", m_apb_penable, 0);
        chk("rst_paddr", m_apb_paddr, 0);
        chk("rst_pwrite", m_apb_pwrite, 0);
        chk("rst_pwdata", m_apb_pwdata, 0);
        chk("rst_pstrb", m_apb_pstrb, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_slverr", rsp_slverr, 0);
        chk("rst_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge pclk);
        prst_n = 1'b1;
        @(negedge pclk);

        // Directed cases.
        run_txn(32'h0000_0010, 1'b1, 32'hA5A5_5A5A, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
        run_txn(32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
        run_txn(32'h0000_0030, 1'b1, 32'hCAFE_F00D, 4'h3, 2, 32'h0, 1'b1, 0, 1'b0);
        run_txn(32'h0000_0034, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_BEEF, 1'b0, 0, 1'b0);
        run_txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 20, 32'h5555_AAAA, 1'b0, 0, 1'b0);
        run_txn(32'h0000_0044, 1'b0, 32'h0, 4'h0, TO - 1, 32'h7777_1111, 1'b0, 0, 1'b0);
        run_txn(32'h0000_0050, 1'b1, 32'h0102_0304, 4'h5, 1, 32'h0, 1'b0, 5, 1'b1);
        run_txn(32'h0000_0054, 1'b0, 32'h0, 4'h0, 0, 32'h8765_4321, 1'b0, 0, 1'b0);

        // Reset asserted in the middle of an ACCESS phase.
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0060;
        cmd_write = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        m_apb_pready = 1'b0;
        repeat (2) @(negedge pclk);
        chk("pre_rst_penable", m_apb_penable, 1);
        prst_n = 1'b0;
        #1;
        chk("midrst_psel", m_apb_psel, 0);
        chk("midrst_penable", m_apb_penable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        prst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("postrst_rsp_valid", rsp_valid, 0);
            chk("postrst_psel", m_apb_psel, 0);
        end
        run_txn(32'h0000_0070, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, 1'($urandom), $urandom, SW'($urandom),
                    int'($urandom_range(0, 11)), $urandom, 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_apb_master_bridge
`default_nettype wire
